// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and stream framing constants for the instruction loader
package imem_loader_pkg;

   // Loader FSM encoding
   localparam logic [2:0] ST_HDR  = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_WR   = 3'd2;
   localparam logic [2:0] ST_DONE = 3'd3;
   localparam logic [2:0] ST_ERR  = 3'd4;

   // Stream framing: 4-byte little-endian header, 4-byte little-endian words
   localparam int HDR_BYTES      = 4;
   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_BITS      = 8 * BYTES_PER_WORD;
   localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// rtl/imem_loader_byte_assembler.sv - collects four bytes little-endian into one word with a last-byte flag
module byte_assembler
   import imem_loader_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 accept,
   input  logic [7:0]           byte_data,
   output logic [WORD_BITS-1:0] word_next,
   output logic                 last
);

   logic [BIDX_W-1:0]    byte_idx;
   logic [WORD_BITS-1:0] shreg;

   // New bytes enter at the top so the first byte of a word ends up in bits [7:0]
   assign word_next = {byte_data, shreg[WORD_BITS-1:8]};
   assign last      = (byte_idx == BIDX_W'(BYTES_PER_WORD - 1));

   // Advance the byte index and shift register only on an accepted byte
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_idx <= '0;
         shreg    <= '0;
      end else if (accept) begin
         byte_idx <= last ? '0 : byte_idx + 1'b1;
         shreg    <= word_next;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a length-prefixed program into instruction memory and releases the core reset
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int addresswidth = 32,
   parameter int datawidth    = 32,
   parameter int depth        = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    byte_valid,
   input  logic [7:0]              byte_data,
   output logic                    byte_ready,
   output logic                    we,
   output logic [addresswidth-1:0] waddr,
   output logic [datawidth-1:0]    wdata,
   output logic                    core_rst_n,
   output logic                    done,
   output logic                    error
);

   localparam int CNT_W = 8 * HDR_BYTES;

   logic [2:0]           state;
   logic [2:0]           next_state;
   logic [CNT_W-1:0]     word_count;
   logic [CNT_W-1:0]     word_idx;
   logic                 accept;
   logic                 asm_last;
   logic [WORD_BITS-1:0] asm_word;
   logic                 hdr_complete;
   logic                 word_complete;
   logic                 last_word;

   // byte_ready is only ever high in HDR/LOAD, so this is the transfer qualifier
   assign accept        = byte_valid & byte_ready;
   assign hdr_complete  = accept & asm_last & (state == ST_HDR);
   assign word_complete = accept & asm_last & (state == ST_LOAD);
   assign last_word     = ((word_idx + CNT_W'(1)) == word_count);

   byte_assembler u_asm (
      .clk       (clk),
      .rst       (rst),
      .accept    (accept),
      .byte_data (byte_data),
      .word_next (asm_word),
      .last      (asm_last)
   );

   // Next-state selection; header decides between empty, oversize and normal loads
   always_comb begin
      next_state = state;
      case (state)
         ST_HDR: begin
            if (hdr_complete) begin
               if (asm_word == '0)
                  next_state = ST_DONE;
               else if (asm_word > CNT_W'(depth))
                  next_state = ST_ERR;
               else
                  next_state = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (word_complete)
               next_state = ST_WR;
         end
         ST_WR: begin
            next_state = last_word ? ST_DONE : ST_LOAD;
         end
         ST_DONE: next_state = ST_DONE;
         ST_ERR:  next_state = ST_ERR;
         default: next_state = ST_HDR;
      endcase
   end

   // State, registered handshake/status outputs and the write port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_HDR;
         byte_ready <= 1'b0;
         we         <= 1'b0;
         waddr      <= '0;
         wdata      <= '0;
         done       <= 1'b0;
         error      <= 1'b0;
         core_rst_n <= 1'b0;
         word_count <= '0;
         word_idx   <= '0;
      end else begin
         state      <= next_state;
         byte_ready <= (next_state == ST_HDR) || (next_state == ST_LOAD);
         we         <= (next_state == ST_WR);
         done       <= done  | (next_state == ST_DONE);
         error      <= error | (next_state == ST_ERR);
         core_rst_n <= (next_state == ST_DONE);
         if (hdr_complete)
            word_count <= asm_word;
         // Capture address and data as the word completes so they are valid throughout WR
         if (word_complete) begin
            waddr <= addresswidth'(word_idx);
            wdata <= datawidth'(asm_word);
         end
         if (state == ST_WR)
            word_idx <= word_idx + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;

   logic        br0, we0, crn0, dn0, er0;
   logic [31:0] wa0, wd0;
   logic        br4, we4, crn4, dn4, er4;
   logic [31:0] wa4, wd4;

   logic [31:0] wa0_q[$], wd0_q[$], wa4_q[$], wd4_q[$];

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   imem_loader #(.addresswidth(32), .datawidth(32), .depth(1024)) dut (
      .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(br0), .we(we0), .waddr(wa0), .wdata(wd0),
      .core_rst_n(crn0), .done(dn0), .error(er0)
   );

   imem_loader #(.addresswidth(32), .datawidth(32), .depth(4)) dut4 (
      .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(br4), .we(we4), .waddr(wa4), .wdata(wd4),
      .core_rst_n(crn4), .done(dn4), .error(er4)
   );

   // Write monitors, sampled on the falling edge
   always @(negedge clk) begin
      if (we0) begin wa0_q.push_back(wa0); wd0_q.push_back(wd0); end
      if (we4) begin wa4_q.push_back(wa4); wd4_q.push_back(wd4); end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic logic sel_rdy(input int sel);
      return sel ? br4 : br0;
   endfunction

   task automatic do_reset(input int sel);
      byte_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("rst_we",    sel ? we4  : we0,  0);
      check("rst_waddr", sel ? wa4  : wa0,  0);
      check("rst_wdata", sel ? wd4  : wd0,  0);
      check("rst_done",  sel ? dn4  : dn0,  0);
      check("rst_error", sel ? er4  : er0,  0);
      check("rst_crn",   sel ? crn4 : crn0, 0);
      check("rst_rdy",   sel_rdy(sel), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rdy_at_release", sel_rdy(sel), 0);
      @(negedge clk);
      check("rdy_rise", sel_rdy(sel), 1);
      wa0_q.delete(); wd0_q.delete(); wa4_q.delete(); wd4_q.delete();
   endtask

   // Present a byte on the falling edge and return just after the edge that transfers it
   task automatic send_byte(input int sel, input logic [7:0] b);
      int t;
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      t = 0;
      while (!sel_rdy(sel) && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("rdy_wait", sel_rdy(sel), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input int sel, input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(sel, w[8*k +: 8]);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      byte_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_write(input int sel, input int i, input logic [31:0] a, input logic [31:0] d);
      int sz;
      sz = sel ? wa4_q.size() : wa0_q.size();
      check($sformatf("waddr[%0d]", i), (i < sz) ? (sel ? wa4_q[i] : wa0_q[i]) : 32'hffff_ffff, a);
      check($sformatf("wdata[%0d]", i), (i < sz) ? (sel ? wd4_q[i] : wd0_q[i]) : 32'hffff_ffff, d);
   endtask

   initial begin
      #2;
      // Two-word program, including write latency
      do_reset(0);
      send_word(0, 32'd2);
      check("crn_loading", crn0, 0);
      send_word(0, 32'h0050_0013);
      @(negedge clk);
      check("we_latency", we0, 1);
      check("wr_rdy_low", br0, 0);
      check("wr_addr0", wa0, 0);
      check("wr_data0", wd0, 32'h0050_0013);
      send_word(0, 32'h00A0_0093);
      idle(3);
      check("t1_nwr", wa0_q.size(), 2);
      check_write(0, 0, 0, 32'h0050_0013);
      check_write(0, 1, 1, 32'h00A0_0093);
      check("t1_done", dn0, 1);
      check("t1_crn", crn0, 1);
      check("t1_rdy", br0, 0);
      check("t1_err", er0, 0);
      check("t1_we_idle", we0, 0);
      check("t1_wdata_hold", wd0, 32'h00A0_0093);

      // Empty program
      do_reset(0);
      send_word(0, 32'd0);
      @(negedge clk);
      check("t2_done", dn0, 1);
      check("t2_crn", crn0, 1);
      check("t2_rdy", br0, 0);
      idle(3);
      check("t2_nwr", wa0_q.size(), 0);

      // Oversize header on depth 4
      do_reset(1);
      send_word(1, 32'd5);
      repeat (4) @(negedge clk);
      check("t3_err", er4, 1);
      check("t3_crn", crn4, 0);
      check("t3_rdy", br4, 0);
      check("t3_done", dn4, 0);
      idle(2);
      check("t3_nwr", wa4_q.size(), 0);

      // Mid-word stall
      do_reset(0);
      send_word(0, 32'd1);
      send_byte(0, 8'h78);
      send_byte(0, 8'h56);
      idle(5);
      send_byte(0, 8'h34);
      send_byte(0, 8'h12);
      idle(4);
      check("t4_nwr", wa0_q.size(), 1);
      check_write(0, 0, 0, 32'h1234_5678);
      check("t4_done", dn0, 1);

      // Reset in the middle of a word, then a fresh stream
      do_reset(0);
      send_word(0, 32'd2);
      send_byte(0, 8'hAA);
      send_byte(0, 8'hBB);
      #2;
      do_reset(0);
      send_word(0, 32'd1);
      send_word(0, 32'hDEAD_BEEF);
      idle(3);
      check("t5_nwr", wa0_q.size(), 1);
      check_write(0, 0, 0, 32'hDEAD_BEEF);
      check("t5_done", dn0, 1);

      // Full-depth program on depth 4, byte_valid kept high afterwards
      do_reset(1);
      send_word(1, 32'd4);
      for (int w = 0; w < 4; w++)
         send_word(1, {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
      repeat (4) begin
         @(negedge clk);
         check("t6_rdy_low", br4, 0);
      end
      check("t6_valid_held", byte_valid, 1);
      check("t6_done", dn4, 1);
      check("t6_crn", crn4, 1);
      check("t6_nwr", wa4_q.size(), 4);
      check_write(1, 0, 0, 32'h0302_0100);
      check_write(1, 1, 1, 32'h0706_0504);
      check_write(1, 2, 2, 32'h0B0A_0908);
      check_write(1, 3, 3, 32'h0F0E_0D0C);
      idle(1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
